// File: rtl/crc_pkg.sv
// Shared CRC definitions for the 1-Wire frame path (Maxim CRC-8, reflected).
// Used by the slave-side checker and the master-side generator.
package crc_pkg;

  localparam logic [7:0] CRC8_POLY_MAXIM = 8'h8C;
  localparam logic [7:0] CRC8_INIT       = 8'h00;
  localparam int         CMD_W           = 56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CMP  = 2'd2
  } crc_chk_state_t;

endpackage

// File: rtl/crc8_bit_step.sv
// Single-bit advance of a reflected CRC-8 register; purely combinational.
module crc8_bit_step (
  input  logic [7:0] crc,
  input  logic       bit_in,
  input  logic [7:0] poly,
  output logic [7:0] crc_next
);

  logic fb;

  assign fb       = crc[0] ^ bit_in;
  assign crc_next = (crc >> 1) ^ (fb ? poly : 8'h00);

endmodule

// File: rtl/crc8_checker.sv
// Bit-serial 1-Wire CRC-8 checker: recomputes the CRC over a command and compares it to the received byte.
// Optional mismatch counter built only when CRC_CHK_ERR_CNT_EN is defined; otherwise o_err_cnt reads 0.
module crc8_checker #(
  parameter int         CMD_W = crc_pkg::CMD_W,
  parameter logic [7:0] POLY  = crc_pkg::CRC8_POLY_MAXIM,
  parameter logic [7:0] INIT  = crc_pkg::CRC8_INIT
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CMD_W-1:0] i_command,
  input  logic [7:0]       i_crc,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic [7:0]       o_calc_crc,
  output logic [7:0]       o_err_cnt
);

  import crc_pkg::*;

  localparam int             CNT_W    = $clog2(CMD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CMD_W - 1);

  crc_chk_state_t   state;
  logic [CMD_W-1:0] shift_q;
  logic [7:0]       ref_q;
  logic [7:0]       crc_q;
  logic [7:0]       crc_next;
  logic [CNT_W-1:0] cnt_q;

  crc8_bit_step u_step (
    .crc      (crc_q),
    .bit_in   (shift_q[0]),
    .poly     (POLY),
    .crc_next (crc_next)
  );

  assign o_busy = (state == CALC) || (state == CMP);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      ref_q      <= 8'h00;
      crc_q      <= 8'h00;
      cnt_q      <= '0;
      o_done     <= 1'b0;
      o_crc_ok   <= 1'b0;
      o_calc_crc <= 8'h00;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            shift_q    <= i_command;
            ref_q      <= i_crc;
            crc_q      <= INIT;
            cnt_q      <= '0;
            o_crc_ok   <= 1'b0;
            o_calc_crc <= 8'h00;
            state      <= CALC;
          end
        end
        // one command bit per clock, LSB of byte 0 first
        CALC: begin
          crc_q   <= crc_next;
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state <= CMP;
        end
        CMP: begin
          o_calc_crc <= crc_q;
          o_crc_ok   <= (crc_q == ref_q);
          o_done     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC_CHK_ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'h01;
  endfunction

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_cnt <= 8'h00;
    end else if (state == CMP && crc_q != ref_q) begin
      o_err_cnt <= sat_inc(o_err_cnt);
    end
  end
`else
  assign o_err_cnt = 8'h00;
`endif

endmodule

// File: doc/crc8_checker.md
Name: crc8_checker

Overview:
- Downstream stage of the slave frame destructor: takes the 56-bit command and 8-bit received CRC it produces and recomputes the 1-Wire CRC-8 (Maxim, x^8+x^5+x^4+1, reflected) over the command.
- Processes one bit per clock through a small FSM, then reports pass/fail with a one-cycle done pulse.
- Its verdict gates command execution in the slave controller.

Parameters:
- CMD_W, 56: command width in bits (>=8, multiple of 8).
- POLY, 8'h8C: reflected CRC polynomial.
- INIT, 8'h00: CRC register initial value.

Ports:
- clk  input  1  system clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_start  input  1  level sampled per clock; accepted only in IDLE; normally the destructor's done flag
- i_command  input  CMD_W  command from destructor; byte 0 (first on wire) in [7:0]
- i_crc  input  8  received CRC byte
- o_busy  output  1  high in CALC and CMP
- o_done  output  1  one-cycle pulse, result valid
- o_crc_ok  output  1  1 = computed CRC equals received CRC; held until next accepted start
- o_calc_crc  output  8  computed CRC; held until next accepted start
- o_err_cnt  output  8  mismatch counter (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; o_busy=0, o_done=0, o_crc_ok=0, o_calc_crc=0, o_err_cnt=0; internal shift reg, ref CRC, bit counter all 0.
- Reset mid-operation: abandons calculation; no o_done is produced for the interrupted frame.
- FSM states: IDLE, CALC, CMP.
- IDLE:
  - On a clock edge with i_start=1, latch i_command into the shift reg and i_crc into ref.
  - Set crc=INIT, counter=0, o_crc_ok=0, o_calc_crc=0; go to CALC.
- CALC, each clock:
  - b = shift[0]; fb = crc[0]^b; crc = (crc>>1) ^ (fb ? POLY : 0).
  - Shift reg shifts right by 1; counter++.
  - Bit order is i_command[0] first through [CMD_W-1] last.
  - After the edge that processes bit CMD_W-1, go to CMP.
- CMP, one clock:
  - o_calc_crc<=crc; o_crc_ok<=(crc==ref); o_done<=1; return to IDLE.
- o_done is cleared on the following clock, so it is exactly one cycle wide.
- Latency: start accepted at edge T0; o_done is high in the cycle after edge T0+CMD_W+1 (57 edges for CMD_W=56).
- i_start while o_busy=1 is ignored; it does not restart, queue or corrupt the calculation.
- i_start held high continuously: a new frame is accepted on the first IDLE edge after CMP, i.e. back-to-back frames every CMD_W+2 clocks.
- Inputs are only sampled at accept; changes to i_command/i_crc during CALC have no effect.
- Counter width is $clog2(CMD_W); it never wraps within a frame.

Optional Feature:
- Macro: CRC_CHK_ERR_CNT_EN.
- Defined: o_err_cnt increments by 1 in CMP when the CRC mismatches. It saturates at 8'hFF, is cleared only by i_reset, and is unaffected by passing frames.
- Undefined: no counter logic is built; o_err_cnt is tied to 8'h00 and the port remains present.

Decomposition:
- Shared package crc_pkg:
  - constants CRC8_POLY_MAXIM=8'h8C and CRC8_INIT=8'h00;
  - state enum type crc_chk_state_t {IDLE, CALC, CMP};
  - CMD_W default 56 (also used by the frame destructor).
- Natural sub-module: crc8_bit_step. Combinational next-CRC from (crc, bit, POLY); the master-side CRC generator reuses it.

Test Plan:
- Reset check: assert i_reset for 3 cycles with no start -> all outputs 0, o_busy=0.
- Known good vector: i_command=56'h00_0000_01B8_1C02, i_crc=8'hA2, start pulse -> o_done after 57 edges; o_crc_ok=1, o_calc_crc=8'hA2; o_err_cnt stays 0.
- Corrupted CRC: same command, i_crc=8'hA3 -> o_crc_ok=0, o_calc_crc=8'hA2; with CRC_CHK_ERR_CNT_EN, o_err_cnt=1.
- All-zero frame: i_command=0, i_crc=0 -> o_crc_ok=1, o_calc_crc=0. Also i_crc=8'h01 -> o_crc_ok=0.
- Busy and back-to-back starts: start the good vector, pulse i_start with the bad vector 10 cycles later -> exactly one o_done, result A2/ok. Then hold i_start high with the bad vector -> next o_done 58 cycles after the first, result not ok.
- Reset mid-calc: assert i_reset 20 cycles after start -> outputs 0, no o_done. A subsequent good frame passes normally.
- Error-counter saturation (macro defined): 260 bad frames -> o_err_cnt=8'hFF. Then one good frame -> count still FF.
